// File: rtl/cu_decode_issue.sv
// Decode/issue stage in front of the PU chain.
// Buffers 32-bit instruction words in a small FIFO, holds one in an issue slot,
// and drives its decoded fields to every PU in parallel. A single chain
// acknowledge from the last PU retires the instruction. A non-NOP word that no
// PU claims halts issue until i_halt_clear discards it.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_insn, i_insn_valid  incoming instruction word and its valid
//   o_insn_ready          FIFO has space (state based, independent of i_chain_ack)
//   o_opcode, o_rega, o_regb, o_regd, o_cmp_op
//                         decoded fields of the slot, zero unless issuing
//   i_chain_ack           some PU handled o_opcode this cycle
//   o_illegal             sticky illegal-instruction flag (high while halted)
//   o_illegal_insn        word that caused the most recent halt
//   i_halt_clear          discard the halted word and resume
//   o_retired             retired-instruction count, wraps
module cu_decode_issue #(
  parameter int unsigned OPTION_OPCODE_WIDTH = 6,
  parameter int unsigned OPTION_FIFO_DEPTH   = 2,
  parameter int unsigned OPTION_COUNT_WIDTH  = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [31:0]                    i_insn,
  input  logic                           i_insn_valid,
  output logic                           o_insn_ready,
  output logic [OPTION_OPCODE_WIDTH-1:0] o_opcode,
  output logic [4:0]                     o_rega,
  output logic [4:0]                     o_regb,
  output logic [4:0]                     o_regd,
  output logic [3:0]                     o_cmp_op,
  input  logic                           i_chain_ack,
  output logic                           o_illegal,
  output logic [31:0]                    o_illegal_insn,
  input  logic                           i_halt_clear,
  output logic [OPTION_COUNT_WIDTH-1:0]  o_retired
);

  localparam int unsigned PTR_W = (OPTION_FIFO_DEPTH > 1) ? $clog2(OPTION_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OPTION_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [31:0]                   mem_q [OPTION_FIFO_DEPTH];
  logic [PTR_W-1:0]              rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]              count_q;
  logic [31:0]                   slot_q;
  logic [31:0]                   illegal_insn_q;
  logic [OPTION_COUNT_WIDTH-1:0] retired_q;

  logic push, pop, retire, halt_enter;
  logic fifo_nonempty;
  logic slot_is_nop;

  assign o_insn_ready  = !i_rst && (count_q < CNT_W'(OPTION_FIFO_DEPTH));
  assign push          = i_insn_valid && o_insn_ready;
  assign fifo_nonempty = (count_q != '0);
  assign slot_is_nop   = (slot_q[31:26] == 6'd0);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next state plus the pop/retire/halt decisions that go with each transition
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    retire     = 1'b0;
    halt_enter = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // NOPs are never acknowledged but still retire
        if (i_chain_ack || slot_is_nop) begin
          retire = 1'b1;
          if (fifo_nonempty) pop = 1'b1;
          else               state_d = ST_EMPTY;
        end else begin
          halt_enter = 1'b1;
          state_d    = ST_HALT;
        end
      end
      ST_HALT: begin
        if (i_halt_clear) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Decode outputs: only an issuing slot reaches the PUs
  always_comb begin
    o_opcode  = '0;
    o_regd    = '0;
    o_rega    = '0;
    o_regb    = '0;
    o_cmp_op  = '0;
    o_illegal = (state_q == ST_HALT);
    if (state_q == ST_ISSUE) begin
      o_opcode = OPTION_OPCODE_WIDTH'(slot_q[31:26]);
      o_regd   = slot_q[25:21];
      o_rega   = slot_q[20:16];
      o_regb   = slot_q[15:11];
      o_cmp_op = slot_q[10:7];
    end
  end

  assign o_illegal_insn = illegal_insn_q;
  assign o_retired      = retired_q;

  // FIFO storage; contents are qualified by count_q so no reset needed
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_insn;
  end

  // FIFO pointers, issue slot, halt capture and retire counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      slot_q         <= '0;
      illegal_insn_q <= '0;
      retired_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        slot_q   <= mem_q[rd_ptr_q];
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (halt_enter) illegal_insn_q <= slot_q;
      if (retire)     retired_q      <= retired_q + OPTION_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cu_decode_issue.sv
// Scoreboard bench for cu_decode_issue. The driver pushes accepted words into
// an expected queue; a monitor plays the PU chain (acks opcodes 1..7), pops the
// queue whenever a non-NOP issues, and handles halts. A 4-bit counter build
// exercises wrap; a default build runs alongside for the full-width count.
module tb_cu_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] insn;
  logic        insn_valid;
  logic        chain_ack;
  logic        halt_clear;

  logic        ready,     ready_w;
  logic [5:0]  opcode,    opcode_w;
  logic [4:0]  rega,      rega_w;
  logic [4:0]  regb,      regb_w;
  logic [4:0]  regd,      regd_w;
  logic [3:0]  cmp_op,    cmp_op_w;
  logic        illegal,   illegal_w;
  logic [31:0] ill_insn,  ill_insn_w;
  logic [3:0]  retired;
  logic [31:0] retired_w;

  always #5 clk = ~clk;

  cu_decode_issue #(.OPTION_COUNT_WIDTH(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_insn(insn), .i_insn_valid(insn_valid),
    .o_insn_ready(ready), .o_opcode(opcode), .o_rega(rega), .o_regb(regb),
    .o_regd(regd), .o_cmp_op(cmp_op), .i_chain_ack(chain_ack),
    .o_illegal(illegal), .o_illegal_insn(ill_insn), .i_halt_clear(halt_clear),
    .o_retired(retired)
  );

  cu_decode_issue u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_insn(insn), .i_insn_valid(insn_valid),
    .o_insn_ready(ready_w), .o_opcode(opcode_w), .o_rega(rega_w), .o_regb(regb_w),
    .o_regd(regd_w), .o_cmp_op(cmp_op_w), .i_chain_ack(chain_ack),
    .o_illegal(illegal_w), .o_illegal_insn(ill_insn_w), .i_halt_clear(halt_clear),
    .o_retired(retired_w)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          issue_log[$];
  int          model_ret = 0;
  int          hold_cycles = 0;
  int          last_push_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit pu_claims(input logic [5:0] op);
    return (op >= 6'd1) && (op <= 6'd7);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    insn       = w;
    insn_valid = 1'b1;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("push_timeout", 64'(n), 64'(0));
      insn_valid = 1'b0;
    end else begin
      last_push_cyc = cyc;
      exp_q.push_back(w);
      @(posedge clk);
      #1;
      insn_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Monitor / PU chain model
  initial begin
    bit          pending = 1'b0;
    bit          halted  = 1'b0;
    int          hcnt    = 0;
    logic [31:0] hw      = '0;
    logic [31:0] w;
    chain_ack  = 1'b0;
    halt_clear = 1'b0;
    forever begin
      @(negedge clk);
      halt_clear = 1'b0;
      if (rst) begin
        pending   = 1'b0;
        halted    = 1'b0;
        model_ret = 0;
        chain_ack = 1'b0;
        continue;
      end
      if (pending) begin
        check("halt_flag", 64'(illegal), 64'(1));
        check("halt_word", 64'(ill_insn), 64'(hw));
        check("halt_opcode_zero", 64'(opcode), 64'(0));
        pending = 1'b0;
        halted  = 1'b1;
        hcnt    = (hold_cycles > 0) ? hold_cycles : int'($urandom_range(1, 5));
      end else if (halted) begin
        check("halt_quiet", 64'({illegal, opcode, regd, rega, regb, cmp_op}), 64'({1'b1, 25'd0}));
        hcnt--;
        if (hcnt <= 0) begin
          halt_clear = 1'b1;
          halted     = 1'b0;
        end
      end else begin
        check("no_illegal", 64'(illegal), 64'(0));
        if (opcode != 6'd0) begin
          // NOPs ahead of this word already retired without showing an opcode
          while (exp_q.size() > 0 && exp_q[0][31:26] == 6'd0) begin
            void'(exp_q.pop_front());
            model_ret++;
          end
          if (exp_q.size() == 0) begin
            check("spurious_issue", 64'(opcode), 64'(0));
          end else begin
            w = exp_q.pop_front();
            issue_log.push_back(cyc);
            check("decode", 64'({opcode, regd, rega, regb, cmp_op}),
                  64'({w[31:26], w[25:21], w[20:16], w[15:11], w[10:7]}));
            check("retired_at_issue", 64'(retired), 64'(model_ret % 16));
            if (pu_claims(w[31:26])) model_ret++;
            else begin
              pending = 1'b1;
              hw      = w;
            end
          end
        end
      end
      chain_ack = (opcode != 6'd0) ? pu_claims(opcode) : 1'($urandom_range(0, 1));
    end
  end

  localparam logic [31:0] W_ADD  = 32'h0861_1000;
  localparam logic [31:0] W_SUB  = 32'h0461_1000;
  localparam logic [31:0] W_ICMP = 32'h0C61_1500;
  localparam logic [31:0] W_ILL  = 32'hFC00_0000;
  localparam logic [31:0] W_A    = 32'h10A4_1000;
  localparam logic [31:0] W_B    = 32'h14C5_2080;

  initial begin
    int          p0;
    int          nops;
    int          nonnop;
    int          total;
    logic [5:0]  op;
    int          r;
    rst        = 1'b1;
    insn       = '0;
    insn_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_decode", 64'({opcode, regd, rega, regb, cmp_op}), 64'(0));
    check("rst_illegal", 64'({illegal, ill_insn}), 64'(0));
    check("rst_retired", 64'(retired_w), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(ready), 64'(1));
    check("post_rst_retired", 64'(retired), 64'(0));

    // ADD then SUB back to back: 2-cycle push-to-issue, then one per cycle
    issue_log.delete();
    send(W_ADD);
    p0 = last_push_cyc;
    send(W_SUB);
    idle(6);
    check("b2b_count", 64'(issue_log.size()), 64'(2));
    if (issue_log.size() == 2) begin
      check("push_to_issue", 64'(issue_log[0] - p0), 64'(2));
      check("b2b_spacing", 64'(issue_log[1] - issue_log[0]), 64'(1));
    end
    check("b2b_retired", 64'(retired_w), 64'(2));

    send(W_ICMP);
    idle(4);
    check("icmp_retired", 64'(retired_w), 64'(3));

    send(32'h0000_0000);
    idle(4);
    check("nop_retired", 64'(retired_w), 64'(4));

    // Illegal word: halt, FIFO fills, then buffered words issue back to back
    hold_cycles = 8;
    issue_log.delete();
    send(W_ILL);
    send(W_A);
    send(W_B);
    @(negedge clk);
    check("halt_full_ready", 64'(ready), 64'(0));
    check("halt_flag_seen", 64'(illegal), 64'(1));
    idle(15);
    check("resume_count", 64'(issue_log.size()), 64'(3));
    if (issue_log.size() == 3)
      check("resume_spacing", 64'(issue_log[2] - issue_log[1]), 64'(1));
    check("resume_ill_hold", 64'(ill_insn), 64'(W_ILL));
    check("resume_retired", 64'(retired_w), 64'(6));

    // Async reset mid-cycle while halted with two words buffered
    hold_cycles = 50;
    send(W_ILL);
    send(W_A);
    send(W_B);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_decode", 64'({opcode, regd, rega, regb, cmp_op}), 64'(0));
    check("arst_illegal", 64'({illegal, ill_insn}), 64'(0));
    check("arst_ready", 64'(ready), 64'(0));
    check("arst_retired", 64'(retired_w), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    hold_cycles = 0;
    @(negedge clk);
    check("arst_rel_ready", 64'(ready), 64'(1));
    idle(5);
    check("arst_dropped", 64'(retired_w), 64'(0));

    // Sixteen retirements wrap the 4-bit counter
    repeat (16) send(W_ADD);
    idle(5);
    check("wrap4", 64'(retired), 64'(0));
    check("wrap32", 64'(retired_w), 64'(16));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      op = 6'($urandom_range(1, 7));
      else if (r < 88) op = 6'd0;
      else             op = 6'($urandom_range(8, 63));
      idle(int'($urandom_range(0, 2)));
      send({op, 26'($urandom)});
    end
    idle(40);

    nops   = 0;
    nonnop = 0;
    foreach (exp_q[k]) begin
      if (exp_q[k][31:26] == 6'd0) nops++;
      else                         nonnop++;
    end
    total = model_ret + nops;
    @(negedge clk);
    check("drain_nonnop_left", 64'(nonnop), 64'(0));
    check("final_retired4", 64'(retired), 64'(total % 16));
    check("final_retired32", 64'(retired_w), 64'(total));
    check("final_idle", 64'({ready, illegal, opcode}), 64'({1'b1, 1'b0, 6'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
